booth_control: RTL and testbench

//   Sequencer for the 3-bit Booth multiplier datapath. Accepts a multiply

---
 rtl/booth_control.sv | 107 ++++++++++
 tb/tb_booth_control.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_control.sv
// Purpose: sequencer for the N-bit Booth multiplier datapath (load, N x evaluate/shift, done).
// Latency: go sampled at edge k -> done pulse in cycle k+2N+2; busy for 2N+1 cycles.
// Backpressure: none; go is sampled only in IDLE, never queued, and ignored while busy.
module booth_control #(
    parameter int N = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [1:0] q,
    output logic       start,
    output logic       fin,
    output logic       resta,
    output logic       desp,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        EVAL  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;

    // State and iteration counter; reset wins over everything, even mid-operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // Next state and control strobes; only EVAL looks at q, everything else is Moore.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        start     = 1'b0;
        fin       = 1'b1;
        resta     = 1'b0;
        desp      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                start     = 1'b1;
                busy      = 1'b1;
                count_nxt = CW'(N);
                state_nxt = EVAL;
            end
            EVAL: begin
                busy = 1'b1;
                // 01 -> add M, 10 -> subtract M, 00/11 -> leave A alone
                case (q)
                    2'b01: begin
                        fin   = 1'b0;
                        resta = 1'b0;
                    end
                    2'b10: begin
                        fin   = 1'b0;
                        resta = 1'b1;
                    end
                    default: begin
                        fin   = 1'b1;
                        resta = 1'b0;
                    end
                endcase
                state_nxt = SHIFT;
            end
            SHIFT: begin
                desp      = 1'b1;
                busy      = 1'b1;
                count_nxt = count - CW'(1);
                // the last iteration is the one that sees count==1 here
                if (count == CW'(1)) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = EVAL;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_control.sv
// Purpose: directed checks of booth_control closed around a behavioural Booth datapath.
// Latency: each scenario runs a bounded number of cycles; no unbounded waits.
// Backpressure: not applicable; stimulus is driven one cycle at a time.
module tb_booth_control;

    logic       clk;
    logic       reset;
    logic       go;
    logic [1:0] q;
    logic       start;
    logic       fin;
    logic       resta;
    logic       desp;
    logic       busy;
    logic       done;

    int checks;
    int failures;
    logic armed;

    // datapath model: A is one bit wider so the most negative M still works
    logic [2:0] mc_in;
    logic [2:0] mp_in;
    logic [3:0] a_reg;
    logic [2:0] q_reg;
    logic       q_m1;
    logic [3:0] m_reg;

    logic [5:0] obs [1:40];
    logic [5:0] res [1:40];

    booth_control #(.N(3)) dut (
        .clk   (clk),
        .reset (reset),
        .go    (go),
        .q     (q),
        .start (start),
        .fin   (fin),
        .resta (resta),
        .desp  (desp),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Booth datapath: load, arithmetic shift of A:Q:q-1, or A +/- M when not frozen
    always @(posedge clk) begin
        if (start) begin
            a_reg <= 4'd0;
            q_reg <= mp_in;
            q_m1  <= 1'b0;
            m_reg <= {mc_in[2], mc_in};
        end else if (desp) begin
            {a_reg, q_reg, q_m1} <= {a_reg[3], a_reg, q_reg};
        end else if (!fin) begin
            a_reg <= resta ? (a_reg - m_reg) : (a_reg + m_reg);
        end
    end

    assign q = {q_reg[0], q_m1};

    // Strobe exclusivity monitored every cycle once reset has been applied
    always @(negedge clk) begin
        if (armed) begin
            assert (!(start && desp));
            checks++;
            if ((start && desp) || (desp && !fin)) begin
                failures++;
                $display("FAIL strobe_excl start=%b desp=%b fin=%b required no start&desp and no desp&!fin",
                         start, desp, fin);
            end
        end
    end

    // Drive go/reset for ncyc cycles and record {start,fin,resta,desp,busy,done} and result
    task automatic run_op(input logic [2:0] mc, input logic [2:0] mp, input int go_hold,
                          input int go_extra, input int rst_at, input int ncyc);
        mc_in = mc;
        mp_in = mp;
        for (int i = 1; i <= ncyc; i++) begin
            go    = (i <= go_hold) || (i == go_extra);
            reset = (i == rst_at);
            @(posedge clk);
            #1;
            obs[i] = {start, fin, resta, desp, busy, done};
            res[i] = {a_reg[2:0], q_reg};
        end
        go    = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        go    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({start, fin, resta, desp, busy, done} !== 6'b010000) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%b required=010000", i,
                         {start, fin, resta, desp, busy, done});
            end
        end
        reset = 1'b0;
        go    = 1'b0;
        armed = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({start, fin, resta, desp, busy, done} !== 6'b010000) begin
                failures++;
                $display("FAIL idle_stay cyc=%0d got=%b required=010000", i,
                         {start, fin, resta, desp, busy, done});
            end
        end
    endtask

    task automatic test_basic();
        logic [5:0] exp_t [1:9];
        exp_t = '{6'b110010, 6'b010010, 6'b010110, 6'b001010, 6'b010110,
                  6'b000010, 6'b010110, 6'b010001, 6'b010000};
        run_op(3'b011, 3'b010, 1, 0, 0, 9);
        for (int i = 1; i <= 9; i++) begin
            checks++;
            if (obs[i] !== exp_t[i]) begin
                failures++;
                $display("FAIL basic_seq cyc=%0d got=%b required=%b", i, obs[i], exp_t[i]);
            end
        end
        checks++;
        if (res[8] !== 6'b000110) begin
            failures++;
            $display("FAIL basic_result got=%b required=000110", res[8]);
        end
    endtask

    task automatic test_signs();
        run_op(3'b101, 3'b010, 1, 0, 0, 9);
        checks++;
        if (res[8] !== 6'b111010 || obs[8] !== 6'b010001) begin
            failures++;
            $display("FAIL neg3x2 result=%b ctl=%b required 111010/010001", res[8], obs[8]);
        end
        // -4 x -4: q per EVAL is 00,00,10 so only the last EVAL subtracts
        run_op(3'b100, 3'b100, 1, 0, 0, 9);
        checks++;
        if (obs[2] !== 6'b010010 || obs[6] !== 6'b001010) begin
            failures++;
            $display("FAIL neg4x4_eval e1=%b e3=%b required 010010/001010", obs[2], obs[6]);
        end
        checks++;
        if (res[8] !== 6'b010000 || obs[8] !== 6'b010001) begin
            failures++;
            $display("FAIL neg4x4 result=%b ctl=%b required 010000/010001", res[8], obs[8]);
        end
    endtask

    task automatic test_go_ignored();
        int done_cnt;
        int busy_falls;
        logic prev_busy;
        run_op(3'b011, 3'b010, 1, 5, 0, 20);
        done_cnt   = 0;
        busy_falls = 0;
        prev_busy  = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (obs[i][0]) done_cnt++;
            if (prev_busy && !obs[i][1]) busy_falls++;
            prev_busy = obs[i][1];
        end
        checks++;
        if (done_cnt != 1 || busy_falls != 1) begin
            failures++;
            $display("FAIL go_ignored dones=%0d busy_falls=%0d required 1/1", done_cnt, busy_falls);
        end
        checks++;
        if (obs[8] !== 6'b010001 || res[8] !== 6'b000110) begin
            failures++;
            $display("FAIL go_ignored_result ctl=%b result=%b required 010001/000110", obs[8], res[8]);
        end
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        run_op(3'b011, 3'b010, 1, 0, 6, 12);
        checks++;
        if (obs[6] !== 6'b010000) begin
            failures++;
            $display("FAIL reset_mid_idle got=%b required=010000", obs[6]);
        end
        done_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            if (obs[i][0]) done_cnt++;
        end
        checks++;
        if (done_cnt != 0) begin
            failures++;
            $display("FAIL reset_mid_nodone dones=%0d required=0", done_cnt);
        end
        run_op(3'b011, 3'b010, 1, 0, 0, 9);
        checks++;
        if (obs[8] !== 6'b010001 || res[8] !== 6'b000110) begin
            failures++;
            $display("FAIL reset_mid_rerun ctl=%b result=%b required 010001/000110", obs[8], res[8]);
        end
    endtask

    task automatic test_back_to_back();
        int done_cnt;
        int exp_pos;
        run_op(3'b011, 3'b010, 30, 0, 0, 40);
        done_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            if (obs[i][0]) begin
                exp_pos = 8 + 9 * done_cnt;
                done_cnt++;
                checks++;
                if (i != exp_pos || res[i] !== 6'b000110) begin
                    failures++;
                    $display("FAIL b2b_done cyc=%0d result=%b required cyc=%0d result=000110",
                             i, res[i], exp_pos);
                end
                if (i < 40) begin
                    checks++;
                    if (obs[i+1] !== 6'b010000) begin
                        failures++;
                        $display("FAIL b2b_idle cyc=%0d got=%b required=010000", i + 1, obs[i+1]);
                    end
                end
            end
        end
        checks++;
        if (done_cnt != 4) begin
            failures++;
            $display("FAIL b2b_count dones=%0d required=4", done_cnt);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        armed    = 1'b0;
        reset    = 1'b0;
        go       = 1'b0;
        mc_in    = 3'b000;
        mp_in    = 3'b000;
        @(negedge clk);
        test_reset();
        test_basic();
        test_signs();
        test_go_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
